// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-in/parallel-out deserialiser.
//   SIPO_MSB_FIRST / SIPO_LSB_FIRST : bit-order selectors for the MSB_FIRST parameter
//   sipo_cw(width)                  : width of the bit counter for a given word width
package sipo_pkg;

  localparam bit SIPO_MSB_FIRST = 1'b1;
  localparam bit SIPO_LSB_FIRST = 1'b0;

  function automatic int sipo_cw(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// Shift register and bit counter of the deserialiser.
// Ports:
//   clk        : rising-edge clock
//   reset_b    : synchronous reset, active-high
//   serial_in  : serial data bit, taken when in_valid=1
//   in_valid   : serial_in is valid this cycle
//   word       : shifted value including the current bit (meaningful when word_done=1)
//   word_done  : the bit taken this cycle completes a word
//   bit_count  : bits held in the current partial word (0..WIDTH-1)
module sipo_shift_core
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = SIPO_MSB_FIRST,
  parameter int CW        = sipo_cw(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic             serial_in,
  input  logic             in_valid,
  output logic [WIDTH-1:0] word,
  output logic             word_done,
  output logic [CW-1:0]    bit_count
);

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_next;
  logic             last_bit;

  always_comb begin
    sr_next = sr;
    if (in_valid) begin
      if (MSB_FIRST == SIPO_MSB_FIRST) begin
        sr_next = {sr[WIDTH-2:0], serial_in};
      end else begin
        sr_next = {serial_in, sr[WIDTH-1:1]};
      end
    end
  end

  assign last_bit  = (bit_count == CW'(WIDTH - 1));
  assign word_done = in_valid & last_bit;
  // The completed word must include the bit arriving this cycle, so it is
  // taken from the combinational next value rather than the register.
  assign word      = sr_next;

  always_ff @(posedge clk) begin
    if (reset_b) begin
      sr        <= '0;
      bit_count <= '0;
    end else begin
      sr <= sr_next;
      if (in_valid) begin
        bit_count <= last_bit ? '0 : bit_count + CW'(1);
      end
    end
  end

endmodule

// File: rtl/sipo_deser.sv
// Parametrised serial-in/parallel-out deserialiser with a one-word holding
// register, valid/ready output handshake and a sticky overrun flag. The serial
// side never stalls; a word completing while the holding register is still
// occupied (and not being consumed) is dropped and flagged.
// Ports:
//   clk         : rising-edge clock
//   reset_b     : synchronous reset, active-high despite the suffix
//   serial_in   : serial data bit, sampled when in_valid=1
//   in_valid    : serial_in carries a valid bit
//   out_ready   : consumer accepts data_out this cycle
//   clr_overrun : single-cycle clear of overrun
//   data_out    : holding register (assembled word)
//   out_valid   : data_out holds an unconsumed word
//   overrun     : sticky, a completed word was dropped
//   bit_count   : bits accepted into the current partial word
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = SIPO_MSB_FIRST,
  parameter int CW        = sipo_cw(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic             serial_in,
  input  logic             in_valid,
  input  logic             out_ready,
  input  logic             clr_overrun,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  output logic             overrun,
  output logic [CW-1:0]    bit_count
);

  logic [WIDTH-1:0] word;
  logic             word_done;
  logic             consume;
  logic             can_load;
  logic             drop;

  sipo_shift_core #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST),
    .CW        (CW)
  ) u_core (
    .clk       (clk),
    .reset_b   (reset_b),
    .serial_in (serial_in),
    .in_valid  (in_valid),
    .word      (word),
    .word_done (word_done),
    .bit_count (bit_count)
  );

  assign consume  = out_valid & out_ready;
  // The holding register can take a new word if empty or emptied this edge.
  assign can_load = ~out_valid | out_ready;
  assign drop     = word_done & ~can_load;

  always_ff @(posedge clk) begin
    if (reset_b) begin
      data_out  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (word_done && can_load) begin
        data_out  <= word;
        out_valid <= 1'b1;
      end else if (consume) begin
        out_valid <= 1'b0;
      end
      // A new drop outranks a coincident clear.
      if (drop) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sipo_deser.sv
// Self-checking bench for sipo_deser: one MSB-first and one LSB-first
// instance (WIDTH=8) share the same stimulus and are compared against a
// behavioural model built from a queue of received bits.
module tb_sipo_deser;

  logic       clk = 1'b0;
  logic       reset_b = 1'b1;
  logic       serial_in = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       clr_overrun = 1'b0;
  logic [7:0] dm_data, dl_data;
  logic       dm_valid, dl_valid, dm_ovr, dl_ovr;
  logic [2:0] dm_cnt, dl_cnt;

  int total = 0;
  int bad = 0;

  // Behavioural model
  bit         m_q[$];
  logic [7:0] m_dm, m_dl;
  logic       m_valid, m_ovr;

  always #5 clk = ~clk;

  sipo_deser #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .reset_b(reset_b), .serial_in(serial_in), .in_valid(in_valid),
    .out_ready(out_ready), .clr_overrun(clr_overrun), .data_out(dm_data),
    .out_valid(dm_valid), .overrun(dm_ovr), .bit_count(dm_cnt)
  );

  sipo_deser #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset_b(reset_b), .serial_in(serial_in), .in_valid(in_valid),
    .out_ready(out_ready), .clr_overrun(clr_overrun), .data_out(dl_data),
    .out_valid(dl_valid), .overrun(dl_ovr), .bit_count(dl_cnt)
  );

  task automatic do_reset();
    reset_b = 1'b1; serial_in = 1'b1; in_valid = 1'b1; out_ready = 1'b0; clr_overrun = 1'b0;
    @(posedge clk);
    m_q.delete(); m_dm = 8'h00; m_dl = 8'h00; m_valid = 1'b0; m_ovr = 1'b0;
    #1;
    reset_b = 1'b0; in_valid = 1'b0;
  endtask

  // One clock with the given inputs; advances the model with the same inputs.
  task automatic drive(input logic si, input logic iv, input logic rdy, input logic clr);
    logic       done;
    logic [7:0] wm, wl;
    logic       lost;
    serial_in = si; in_valid = iv; out_ready = rdy; clr_overrun = clr;
    @(posedge clk);
    done = 1'b0; wm = 8'h00; wl = 8'h00;
    if (iv) begin
      m_q.push_back(si);
      if (m_q.size() == 8) begin
        done = 1'b1;
        for (int i = 0; i < 8; i++) begin
          wm[7-i] = m_q[i];
          wl[i]   = m_q[i];
        end
        m_q.delete();
      end
    end
    lost = done && m_valid && !rdy;
    if (done && !lost) begin
      m_dm = wm; m_dl = wl; m_valid = 1'b1;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    if (lost) m_ovr = 1'b1;
    else if (clr) m_ovr = 1'b0;
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic rdy_last, input logic rdy_rest);
    for (int i = 0; i < 8; i++)
      drive(b[7-i], 1'b1, (i == 7) ? rdy_last : rdy_rest, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({dm_data, dm_valid, dm_ovr, dm_cnt} !== 13'd0 || {dl_data, dl_valid, dl_ovr, dl_cnt} !== 13'd0) begin
      bad++;
      $display("FAIL reset_state: msb=%h/%b/%b/%0d lsb=%h/%b/%b/%0d required all zero",
               dm_data, dm_valid, dm_ovr, dm_cnt, dl_data, dl_valid, dl_ovr, dl_cnt);
    end
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    total++;
    if (dm_cnt !== 3'd3) begin
      bad++; $display("FAIL partial_count: got %0d required 3", dm_cnt);
    end
    do_reset();
    total++;
    if (dm_cnt !== 3'd0 || dl_cnt !== 3'd0) begin
      bad++; $display("FAIL reset_mid_word_count: got %0d/%0d required 0", dm_cnt, dl_cnt);
    end
    send_byte(8'hFF, 1'b1, 1'b1);
    total++;
    if (dm_valid !== 1'b1 || dm_data !== 8'hFF || dl_data !== 8'hFF) begin
      bad++; $display("FAIL reset_residue: msb=%h lsb=%h valid=%b required FF FF 1", dm_data, dl_data, dm_valid);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_bit_order();
    logic [7:0] b = 8'hB2;
    for (int i = 0; i < 7; i++) drive(b[7-i], 1'b1, 1'b1, 1'b0);
    total++;
    if (dm_valid !== 1'b0) begin
      bad++; $display("FAIL early_valid: got %b required 0", dm_valid);
    end
    drive(b[0], 1'b1, 1'b1, 1'b0);
    total++;
    if (dm_valid !== 1'b1 || dm_data !== 8'hB2 || dm_data !== m_dm) begin
      bad++; $display("FAIL msb_first_word: got %h valid=%b required B2 valid=1", dm_data, dm_valid);
    end
    total++;
    if (dl_valid !== 1'b1 || dl_data !== 8'h4D || dl_data !== m_dl) begin
      bad++; $display("FAIL lsb_first_word: got %h valid=%b required 4D valid=1", dl_data, dl_valid);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    total++;
    if (dm_valid !== 1'b0 || dl_valid !== 1'b0 || dm_data !== 8'hB2) begin
      bad++; $display("FAIL valid_one_cycle: valid=%b/%b data=%h required 0/0 B2", dm_valid, dl_valid, dm_data);
    end
  endtask

  task automatic test_gaps();
    logic [7:0] b = 8'hB2;
    for (int i = 0; i < 8; i++) begin
      drive(b[7-i], 1'b1, 1'b1, 1'b0);
      if (i < 7) begin
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        total++;
        if (dm_cnt !== 3'(i + 1) || dm_cnt !== 3'(m_q.size())) begin
          bad++; $display("FAIL gap_count_%0d: got %0d required %0d", i, dm_cnt, i + 1);
        end
      end
    end
    total++;
    if (dm_valid !== 1'b1 || dm_data !== 8'hB2 || dm_cnt !== 3'd0) begin
      bad++; $display("FAIL gap_word: got %h valid=%b cnt=%0d required B2 1 0", dm_data, dm_valid, dm_cnt);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_overrun();
    send_byte(8'hB2, 1'b0, 1'b0);
    send_byte(8'h11, 1'b0, 1'b0);
    total++;
    if (dm_data !== 8'hB2 || dm_valid !== 1'b1 || dm_ovr !== 1'b1 || dm_cnt !== 3'd0) begin
      bad++; $display("FAIL overrun_hold: data=%h valid=%b ovr=%b cnt=%0d required B2 1 1 0",
                      dm_data, dm_valid, dm_ovr, dm_cnt);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    total++;
    if (dm_valid !== 1'b0 || dm_ovr !== 1'b1) begin
      bad++; $display("FAIL overrun_consume: valid=%b ovr=%b required 0 1", dm_valid, dm_ovr);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    total++;
    if (dm_ovr !== 1'b0 || dl_ovr !== 1'b0) begin
      bad++; $display("FAIL overrun_clear: got %b/%b required 0", dm_ovr, dl_ovr);
    end
    // A drop coinciding with a clear must leave overrun set.
    send_byte(8'h3C, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    total++;
    if (dm_ovr !== 1'b1 || dm_data !== 8'h3C || m_ovr !== 1'b1) begin
      bad++; $display("FAIL set_beats_clear: ovr=%b data=%h required 1 3C", dm_ovr, dm_data);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_back_to_back();
    send_byte(8'hB2, 1'b0, 1'b0);
    send_byte(8'h5A, 1'b1, 1'b0);
    total++;
    if (dm_valid !== 1'b1 || dm_data !== 8'h5A || dm_ovr !== 1'b0) begin
      bad++; $display("FAIL complete_and_consume: valid=%b data=%h ovr=%b required 1 5A 0",
                      dm_valid, dm_data, dm_ovr);
    end
    total++;
    if (dl_data !== 8'h5A) begin
      bad++; $display("FAIL complete_and_consume_lsb: got %h required 5A", dl_data);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 15) == 0));
      total++;
      if (dm_data !== m_dm || dl_data !== m_dl || dm_valid !== m_valid || dl_valid !== m_valid ||
          dm_ovr !== m_ovr || dl_ovr !== m_ovr || dm_cnt !== 3'(m_q.size()) || dl_cnt !== 3'(m_q.size())) begin
        bad++;
        $display("FAIL random_%0d: msb=%h/%b/%b/%0d lsb=%h/%b/%b/%0d required %h/%h/%b/%b/%0d",
                 n, dm_data, dm_valid, dm_ovr, dm_cnt, dl_data, dl_valid, dl_ovr, dl_cnt,
                 m_dm, m_dl, m_valid, m_ovr, m_q.size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_bit_order();
    test_gaps();
    test_overrun();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
